// File: rtl/var_delay_line.sv
// Variable-length sample delay line: circular RAM with programmable tap, fill tracking FSM.
// Define VDL_ZERO_MASK_EN to force dat_out to zero whenever dat_val is low.
module var_delay_line #(
  parameter int WIDTH = 32,
  parameter int D     = 64,
  parameter int B     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             flush,
  input  logic             dly_set,
  input  logic [B-1:0]     dly_len,
  input  logic [WIDTH-1:0] dat_in,
  output logic [WIDTH-1:0] dat_out,
  output logic             dat_val,
  output logic [B:0]       fill_cnt
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} fill_state_t;

  localparam logic [B:0] LAST_CNT = (B+1)'(D - 1);

  fill_state_t      state_reg, state_next;
  logic [B-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [B-1:0]     len_reg, len_next;
  logic [B:0]       fill_reg, fill_next;
  logic [B-1:0]     rd_addr;
  logic [B:0]       dly_samples;
  logic [WIDTH-1:0] rd_data;
  logic             accept;

  logic [WIDTH-1:0] ram [D];

  // flush beats ena, so a sample arriving with flush never lands in the RAM
  assign accept = ena & ~flush;

  always_ff @(posedge clk) begin
    if (accept) begin
      ram[wr_ptr_reg] <= dat_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= EMPTY;
      wr_ptr_reg <= '0;
      fill_reg   <= '0;
      len_reg    <= '1;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      fill_reg   <= fill_next;
      len_reg    <= len_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    fill_next   = fill_reg;
    len_next    = dly_set ? dly_len : len_reg;
    if (flush) begin
      state_next  = EMPTY;
      wr_ptr_next = '0;
      fill_next   = '0;
    end else if (ena) begin
      wr_ptr_next = wr_ptr_reg + B'(1);
      case (state_reg)
        EMPTY: begin
          fill_next  = fill_reg + (B+1)'(1);
          state_next = (D == 1) ? FULL : FILLING;
        end
        FILLING: begin
          fill_next = fill_reg + (B+1)'(1);
          if (fill_reg == LAST_CNT) begin
            state_next = FULL;
          end
        end
        FULL: begin
          fill_next = fill_reg;
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  // L = len_reg+1; B-bit wraparound makes L=D read back at wr_ptr itself
  assign dly_samples = {1'b0, len_reg} + (B+1)'(1);
  assign rd_addr     = wr_ptr_reg - len_reg - B'(1);
  assign rd_data     = ram[rd_addr];
  assign dat_val     = (fill_reg >= dly_samples);
  assign fill_cnt    = fill_reg;

`ifdef VDL_ZERO_MASK_EN
  assign dat_out = dat_val ? rd_data : '0;
`else
  assign dat_out = rd_data;
`endif

endmodule

// File: tb/tb_var_delay_line.sv
// Directed bench for var_delay_line: ramp, programmable length, ena gaps, flush and async reset.
// Output-zero checks on invalid samples apply only when VDL_ZERO_MASK_EN is defined.
module tb_var_delay_line;

  localparam int WIDTH = 32;
  localparam int D     = 64;
  localparam int B     = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ena = 1'b0;
  logic             flush = 1'b0;
  logic             dly_set = 1'b0;
  logic [B-1:0]     dly_len = '0;
  logic [WIDTH-1:0] dat_in = '0;
  logic [WIDTH-1:0] dat_out;
  logic             dat_val;
  logic [B:0]       fill_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  var_delay_line #(.WIDTH(WIDTH), .D(D), .B(B)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .flush   (flush),
    .dly_set (dly_set),
    .dly_len (dly_len),
    .dat_in  (dat_in),
    .dat_out (dat_out),
    .dat_val (dat_val),
    .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Outputs are checked for the sample currently presented on dat_in.
  task automatic expect_out(input string tag, input int fill, input bit val, input int dout);
    $display("[TB] %s ena=%0b flush=%0b set=%0b din=%0d fill=%0d val=%0b dout=%0d",
             tag, ena, flush, dly_set, dat_in, fill_cnt, dat_val, dat_out);
    check({tag, ".fill"}, 32'(fill_cnt), fill);
    check({tag, ".val"}, 32'(dat_val), 32'(val));
    if (val) begin
      check({tag, ".dout"}, dat_out, dout);
    end else begin
`ifdef VDL_ZERO_MASK_EN
      check({tag, ".dout0"}, dat_out, 0);
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse placed between clock edges; effects must be visible before any edge.
  task automatic pulse_reset(input string tag);
    ena = 1'b0; flush = 1'b0; dly_set = 1'b0;
    rst = 1'b1;
    #1;
    $display("[TB] %s async reset fill=%0d val=%0b dout=%0d", tag, fill_cnt, dat_val, dat_out);
    check({tag, ".rst_fill"}, 32'(fill_cnt), 0);
    check({tag, ".rst_val"}, 32'(dat_val), 0);
`ifdef VDL_ZERO_MASK_EN
    check({tag, ".rst_dout"}, dat_out, 0);
`endif
    #1;
    rst = 1'b0;
  endtask

  task automatic set_len(input int len);
    ena = 1'b0; dly_set = 1'b1; dly_len = B'(len);
    tick();
    dly_set = 1'b0;
  endtask

  initial begin
    #1;
    check("reset.fill", 32'(fill_cnt), 0);
    check("reset.val", 32'(dat_val), 0);
`ifdef VDL_ZERO_MASK_EN
    check("reset.dout", dat_out, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Default L=D: output valid only once input D+1 is presented
    for (int i = 1; i <= 70; i++) begin
      dat_in = 32'(i); ena = 1'b1;
      expect_out("ramp", (i - 1 > D) ? D : i - 1, i >= D + 1, i - D);
      tick();
    end
    dat_in = 32'd71;
    pulse_reset("midrst");

    // L=4 with continuous ramp
    set_len(3);
    for (int i = 1; i <= 12; i++) begin
      dat_in = 32'(i); ena = 1'b1;
      expect_out("l4", i - 1, i >= 5, i - 4);
      tick();
    end

    // L=4 with ena gaps: idle cycles must hold state and output
    pulse_reset("gaprst");
    set_len(3);
    for (int k = 1; k <= 8; k++) begin
      dat_in = 32'(k); ena = 1'b1;
      expect_out("gap_on", k - 1, k >= 5, k - 4);
      tick();
      dat_in = 32'hdead_0000 + 32'(k); ena = 1'b0;
      expect_out("gap_off", k, k >= 4, k - 3);
      tick();
    end

    // Lengthen L=4 -> 16 after 10 writes, then shorten to 2 together with a write
    pulse_reset("lenrst");
    set_len(3);
    for (int i = 1; i <= 10; i++) begin
      dat_in = 32'(i); ena = 1'b1;
      expect_out("pre16", i - 1, i >= 5, i - 4);
      tick();
    end
    ena = 1'b0; dly_set = 1'b1; dly_len = 6'd15; dat_in = 32'd11;
    expect_out("set16", 10, 1'b1, 7);
    tick();
    dly_set = 1'b0;
    for (int i = 11; i <= 20; i++) begin
      dat_in = 32'(i); ena = 1'b1;
      expect_out("l16", i - 1, i >= 17, i - 16);
      tick();
    end
    dat_in = 32'd21; ena = 1'b1; dly_set = 1'b1; dly_len = 6'd1;
    expect_out("set2", 20, 1'b1, 5);
    tick();
    dly_set = 1'b0;
    for (int i = 22; i <= 24; i++) begin
      dat_in = 32'(i); ena = 1'b1;
      expect_out("l2", i - 1, 1'b1, i - 2);
      tick();
    end

    // Flush with ena on the same edge: sample 99 is discarded, pointer restarts at 0
    dat_in = 32'd99; ena = 1'b1; flush = 1'b1;
    expect_out("flush", 24, 1'b1, 23);
    tick();
    flush = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      dat_in = 32'(100 + k); ena = 1'b1;
      expect_out("postflush", k - 1, k >= 3, 100 + k - 2);
      tick();
    end
    ena = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
